// File: rtl/jtkonami_tilemap_render_if.sv
// Memory-side bus of the tilemap renderer: scan RAM read port, ROM request port
// and line buffer write port.
interface jtkonami_tilemap_render_if #(
  parameter int DW   = 16,
  parameter int CW   = 13,
  parameter int PALW = 4,
  parameter int HW   = 9,
  parameter int AW   = 18,
  parameter int SAW  = 10
);
  logic [SAW-1:0]       scan_addr;
  logic [CW+PALW+1:0]   scan_data;
  // ROM handshake: rom_cs rises with rom_addr already stable; both hold until the
  // requester sees rom_ok on a cycle after the first, then rom_cs drops next clock.
  logic                 rom_cs;
  logic [AW-1:0]        rom_addr;
  logic                 rom_ok;
  logic [DW-1:0]        rom_data;
  logic                 line;
  logic                 line_we;
  logic [HW:0]          line_addr;
  logic [PALW+3:0]      line_din;

  modport master (
    output scan_addr, rom_cs, rom_addr, line, line_we, line_addr, line_din,
    input  scan_data, rom_ok, rom_data
  );

  modport slave (
    input  scan_addr, rom_cs, rom_addr, line, line_we, line_addr, line_din,
    output scan_data, rom_ok, rom_data
  );
endinterface

// File: rtl/jtkonami_tilemap_render.sv
// Per-line 4bpp tilemap renderer into a double line buffer.
// Optional JTKONAMI_TMAP_TRANSP_EN: skip writes of pixel value 0.
module jtkonami_tilemap_render #(
  parameter int DW   = 16,
  parameter int TW   = 8,
  parameter int CW   = 13,
  parameter int PALW = 4,
  parameter int HW   = 9,
  parameter int HEND = 320,
  parameter int AW   = 18,
  parameter int SAW  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hs_i,
  input  logic       lvbl_i,
  input  logic [7:0] vrender_i,
  input  logic [8:0] hscr_i,
  input  logic [7:0] vscr_i,
  input  logic       flip_i,
  output logic       done_o,
  output logic [2:0] state_o,
  jtkonami_tilemap_render_if.master bus
);
  localparam int PPW = DW / 4;
  localparam int TB  = $clog2(TW);
  localparam int PB  = $clog2(PPW);
  localparam int WB  = $clog2(TW * 4 / DW);

  typedef enum logic [2:0] {
    S_IDLE, S_SCAN, S_SCANW, S_ROMREQ, S_DUMP, S_NEXT
  } state_t;

  state_t          state_q;
  logic            hs_q, line_q, done_q, first_q;
  logic [8:0]      hscr_q;
  logic [7:0]      vscr_q;
  logic [HW:0]     pxcnt_q;
  logic [PB-1:0]   pix_q;
  logic [CW-1:0]   code_q;
  logic [PALW-1:0] pal_q;
  logic            hflip_q, vflip_q;
  logic [DW-1:0]   data_q;
  logic            rom_cs_q, line_we_q;
  logic [AW-1:0]   rom_addr_q;
  logic [HW:0]     line_addr_q;
  logic [PALW+3:0] line_din_q;

  logic            start, in_win, wr_en, last_pix;
  logic [7:0]      vn, hn;
  logic [TB-1:0]   row;
  logic [WB-1:0]   word;
  logic [HW:0]     fine_ext, px_end, x_raw;
  logic [HW-1:0]   x_pos;
  logic [3:0]      pix;
  logic [CW-1:0]   scan_code;
  logic            scan_hf, scan_vf;

  assign start = hs_i & ~hs_q & lvbl_i;
  assign vn    = vrender_i + vscr_q;
  // Walk starts tile-aligned; the fine scroll is applied by the write window.
  assign hn    = {hscr_q[7:TB], {TB{1'b0}}} + pxcnt_q[7:0];
  assign row   = vn[TB-1:0];
  assign word  = hn[TB-1:PB];

  assign fine_ext = (HW+1)'(hscr_q[TB-1:0]);
  assign px_end   = (HW+1)'(HEND) + fine_ext;
  assign x_raw    = pxcnt_q - fine_ext;
  assign x_pos    = flip_i ? (HW'(HEND-1) - x_raw[HW-1:0]) : x_raw[HW-1:0];
  assign in_win   = (pxcnt_q >= fine_ext) && (pxcnt_q < px_end);
  assign pix      = hflip_q ? data_q[3:0] : data_q[DW-1 -: 4];
  assign last_pix = (pix_q == PB'(PPW-1)) || (pxcnt_q + 1'b1 == px_end);

`ifdef JTKONAMI_TMAP_TRANSP_EN
  assign wr_en = in_win && (pix != 4'd0);
`else
  assign wr_en = in_win;
`endif

  assign scan_code = bus.scan_data[CW-1:0];
  assign scan_hf   = bus.scan_data[CW+PALW];
  assign scan_vf   = bus.scan_data[CW+PALW+1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      hs_q        <= 1'b0;
      line_q      <= 1'b0;
      done_q      <= 1'b1;
      first_q     <= 1'b0;
      hscr_q      <= '0;
      vscr_q      <= '0;
      pxcnt_q     <= '0;
      pix_q       <= '0;
      code_q      <= '0;
      pal_q       <= '0;
      hflip_q     <= 1'b0;
      vflip_q     <= 1'b0;
      data_q      <= '0;
      rom_cs_q    <= 1'b0;
      rom_addr_q  <= '0;
      line_we_q   <= 1'b0;
      line_addr_q <= '0;
      line_din_q  <= '0;
    end else begin
      hs_q      <= hs_i;
      line_we_q <= 1'b0;
      if (start) begin
        line_q   <= ~line_q;
        hscr_q   <= hscr_i;
        vscr_q   <= vscr_i;
        pxcnt_q  <= '0;
        done_q   <= 1'b0;
        rom_cs_q <= 1'b0;
        state_q  <= S_SCAN;
      end else begin
        case (state_q)
          S_IDLE: ;
          S_SCAN: state_q <= S_SCANW;
          S_SCANW: begin
            code_q     <= scan_code;
            pal_q      <= bus.scan_data[CW +: PALW];
            hflip_q    <= scan_hf;
            vflip_q    <= scan_vf;
            rom_addr_q <= AW'({scan_code, row ^ {TB{scan_vf}}, word ^ {WB{scan_hf}}});
            rom_cs_q   <= 1'b1;
            first_q    <= 1'b1;
            state_q    <= S_ROMREQ;
          end
          S_ROMREQ: begin
            first_q <= 1'b0;
            if (!first_q && bus.rom_ok) begin
              data_q   <= bus.rom_data;
              rom_cs_q <= 1'b0;
              pix_q    <= '0;
              state_q  <= S_DUMP;
            end
          end
          S_DUMP: begin
            line_we_q   <= wr_en;
            line_addr_q <= {line_q, x_pos};
            line_din_q  <= {pal_q, pix};
            data_q      <= hflip_q ? (data_q >> 4) : (data_q << 4);
            pxcnt_q     <= pxcnt_q + 1'b1;
            pix_q       <= pix_q + 1'b1;
            if (last_pix) state_q <= S_NEXT;
          end
          S_NEXT: begin
            if (pxcnt_q == px_end) begin
              done_q  <= 1'b1;
              state_q <= S_IDLE;
            end else if (pxcnt_q[TB-1:0] != '0) begin
              rom_addr_q <= AW'({code_q, row ^ {TB{vflip_q}}, word ^ {WB{hflip_q}}});
              rom_cs_q   <= 1'b1;
              first_q    <= 1'b1;
              state_q    <= S_ROMREQ;
            end else begin
              state_q <= S_SCAN;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  wire unused_ok = &{1'b0, hscr_q[8], x_raw[HW], hn[PB-1:0]};

  assign done_o        = done_q;
  assign state_o       = state_q;
  assign bus.scan_addr = SAW'({vn[7:TB], hn[7:TB]});
  assign bus.rom_cs    = rom_cs_q;
  assign bus.rom_addr  = rom_addr_q;
  assign bus.line      = line_q;
  assign bus.line_we   = line_we_q;
  assign bus.line_addr = line_addr_q;
  assign bus.line_din  = line_din_q;
endmodule

// File: tb/tb_jtkonami_tilemap_render.sv
// Scoreboard bench for jtkonami_tilemap_render: directed lines with hand-derived
// pixel streams, ROM latency/eager-ok model and mid-line restart.
module tb_jtkonami_tilemap_render;
  localparam int DW = 16, TW = 8, CW = 13, PALW = 4, HW = 9, HEND = 320, AW = 18, SAW = 10;
  localparam int EW = HW + 1 + PALW + 4;

  // clock / reset
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic       hs = 1'b0, lvbl = 1'b1, flip = 1'b0;
  logic [7:0] vrender = '0, vscr = '0;
  logic [8:0] hscr = '0;
  logic       done;
  logic [2:0] state;

  jtkonami_tilemap_render_if #(.DW(DW), .CW(CW), .PALW(PALW), .HW(HW), .AW(AW), .SAW(SAW)) bus ();

  jtkonami_tilemap_render #(
    .DW(DW), .TW(TW), .CW(CW), .PALW(PALW), .HW(HW), .HEND(HEND), .AW(AW), .SAW(SAW)
  ) dut (
    .clk(clk), .rst(rst), .hs_i(hs), .lvbl_i(lvbl), .vrender_i(vrender),
    .hscr_i(hscr), .vscr_i(vscr), .flip_i(flip), .done_o(done), .state_o(state),
    .bus(bus)
  );

  // memory models
  logic [CW+PALW+1:0] scan_mem [0:1023];
  always @(posedge clk) bus.scan_data <= scan_mem[bus.scan_addr];

  logic [DW-1:0] rom_good = 16'h1234, rom_garb = 16'hEEEE;
  int  lat = 1;
  bit  eager = 1'b0;
  int  cs_cnt = 0;
  always @(posedge clk) cs_cnt <= bus.rom_cs ? cs_cnt + 1 : 0;
  assign bus.rom_ok   = bus.rom_cs && (eager || cs_cnt >= lat);
  assign bus.rom_data = (cs_cnt >= lat) ? rom_good : rom_garb;

  // scoreboard
  int n_checks = 0, n_fail = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] got_w, exp_w;
  bit   sb_en = 1'b0;
  int   wr_cnt = 0, cs_rises = 0, stab_err = 0;
  logic cs_prev = 1'b0;
  logic [AW-1:0] first_addr = '0, last_addr = '0;
  logic exp_line = 1'b0;

  always @(negedge clk) begin
    if (bus.line_we) begin
      wr_cnt++;
      if (sb_en) begin
        got_w = {bus.line_addr, bus.line_din};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL line_write: got addr %0h din %0h, none expected", bus.line_addr, bus.line_din);
        end else begin
          exp_w = exp_q.pop_front();
          if (got_w !== exp_w) begin
            n_fail++;
            $display("FAIL line_write: got addr %0h din %0h, expected addr %0h din %0h",
                     got_w[EW-1:PALW+4], got_w[PALW+3:0], exp_w[EW-1:PALW+4], exp_w[PALW+3:0]);
          end
        end
      end
    end
    if (bus.rom_cs && !cs_prev) begin
      cs_rises++;
      if (cs_rises == 1) first_addr = bus.rom_addr;
    end
    if (bus.rom_cs && cs_prev && bus.rom_addr !== last_addr) stab_err++;
    cs_prev   = bus.rom_cs;
    last_addr = bus.rom_addr;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // driver tasks
  task automatic fill_scan(input int code, input int pal, input bit hf, input bit vf);
    for (int i = 0; i < 1024; i++) scan_mem[i] = {vf, hf, PALW'(pal), CW'(code)};
  endtask

  task automatic start_line();
    @(posedge clk); #1 hs = 1'b1;
    @(posedge clk); #1 hs = 1'b0;
    if (lvbl) exp_line = ~exp_line;
  endtask

  // pat lists the four pixels in screen order, repeating every PPW pixels
  task automatic push_line(input logic ln, input int fine, input logic [15:0] pat,
                           input logic [3:0] pal, input bit fl);
    logic [3:0] px;
    int x;
    for (int p = fine; p < HEND + fine; p++) begin
      px = pat[15 - 4*(p % 4) -: 4];
      x  = p - fine;
      if (fl) x = HEND - 1 - x;
`ifdef JTKONAMI_TMAP_TRANSP_EN
      if (px != 4'd0)
`endif
      exp_q.push_back({ln, x[HW-1:0], pal, px});
    end
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 6000; i++) begin
      @(posedge clk); #1;
      if (done) break;
    end
    check({name, " done"}, done, 1);
  endtask

  task automatic run_line(input string name, input int fine, input logic [15:0] pat,
                          input logic [3:0] pal, input bit fl);
    int n_exp;
    exp_q.delete();
    wr_cnt = 0; cs_rises = 0; stab_err = 0;
    sb_en = 1'b1;
    start_line();
    push_line(exp_line, fine, pat, pal, fl);
    n_exp = exp_q.size();
    wait_done(name);
    check({name, " drained"}, exp_q.size(), 0);
    check({name, " writes"}, wr_cnt, n_exp);
    check({name, " line"}, bus.line, exp_line);
  endtask

  initial begin
    fill_scan(5, 3, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    check("rst done", done, 1);
    check("rst rom_cs", bus.rom_cs, 0);
    check("rst line_we", bus.line_we, 0);
    check("rst line", bus.line, 0);
    check("rst line_din", bus.line_din, 0);
    check("rst line_addr", bus.line_addr, 0);
    check("rst state", state, 0);

    // HS during vblank: nothing happens
    lvbl = 1'b0; cs_rises = 0;
    start_line();
    repeat (20) @(posedge clk);
    #1;
    check("vbl rom_cs rises", cs_rises, 0);
    check("vbl done", done, 1);
    check("vbl line", bus.line, 0);
    lvbl = 1'b1;

    run_line("base", 0, 16'h1234, 4'd3, 1'b0);
    check("base rom_addr", first_addr, 32'(18'd80));
    check("base rom words", cs_rises, 80);

    hscr = 9'd3;
    run_line("fine3", 3, 16'h1234, 4'd3, 1'b0);
    hscr = 9'd0;

    // vn = 1 + 1 = 2, vflip gives row 5, hflip gives word 1 first
    fill_scan(5, 3, 1'b1, 1'b1);
    vrender = 8'd1; vscr = 8'd1; rom_good = 16'hABCD;
    run_line("hvflip", 0, 16'hDCBA, 4'd3, 1'b0);
    check("hvflip rom_addr", first_addr, 32'(18'd91));
    vrender = 8'd0; vscr = 8'd0; rom_good = 16'h1234;
    fill_scan(5, 3, 1'b0, 1'b0);

    eager = 1'b1;
    run_line("eager_ok", 0, 16'h1234, 4'd3, 1'b0);
    eager = 1'b0;

    lat = 10;
    run_line("stall", 0, 16'h1234, 4'd3, 1'b0);
    check("stall addr stable", stab_err, 0);
    lat = 1;

    flip = 1'b1;
    run_line("flip", 0, 16'h1234, 4'd3, 1'b0 | 1'b1);
    flip = 1'b0;

    fill_scan(7, 9, 1'b0, 1'b0);
    rom_good = 16'h1030;
    run_line("zero_pix", 0, 16'h1030, 4'd9, 1'b0);
    check("zero_pix rom_addr", first_addr, 32'(18'd112));
    rom_good = 16'h1234;
    fill_scan(5, 3, 1'b0, 1'b0);

    // restart mid-line
    sb_en = 1'b0;
    start_line();
    repeat (100) @(posedge clk);
    start_line();
    check("abort rom_cs", bus.rom_cs, 0);
    check("abort line_we", bus.line_we, 0);
    check("abort line", bus.line, exp_line);
    check("abort done", done, 0);
    exp_q.delete();
    wr_cnt = 0;
    push_line(exp_line, 0, 16'h1234, 4'd3, 1'b0);
    sb_en = 1'b1;
    wait_done("abort");
    check("abort drained", exp_q.size(), 0);
    check("abort writes", wr_cnt, HEND);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
